// File: rtl/history_write_packer.sv
// Packs narrow input beats into MATCH_PE_WIDTH-byte history words and drives the
// shared history write port with the absolute byte address of each word.
module history_write_packer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MATCH_PE_WIDTH = 16,
    parameter int IN_BYTES       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    input  logic [ADDR_WIDTH-1:0]       cfg_addr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_BYTES*8-1:0]       in_data,
    input  logic                        in_last,
    output logic [ADDR_WIDTH-1:0]       write_addr,
    output logic [MATCH_PE_WIDTH*8-1:0] write_data,
    output logic                        write_enable,
    output logic                        busy,
    output logic                        done
);

    localparam int NBEATS = MATCH_PE_WIDTH / IN_BYTES;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int BEAT_W = IN_BYTES * 8;
    localparam int WORD_W = MATCH_PE_WIDTH * 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(MATCH_PE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(MATCH_PE_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(NBEATS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [WORD_W-1:0]       pack_buf;
    logic [WORD_W-1:0]       merged;
    logic                    accept;
    logic                    emit;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        emit      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) state_nxt = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                emit     = in_valid && ((cnt == CNT_LAST) || in_last);
                if (in_valid && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current buffer with the incoming beat dropped into its slot; bytes above stay 0.
    always_comb begin
        merged = pack_buf;
        for (int i = 0; i < NBEATS; i++) begin
            if (cnt == CNT_W'(i)) merged[i*BEAT_W +: BEAT_W] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            addr_reg     <= '0;
            pack_buf     <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            done         <= 1'b0;
        end else begin
            write_enable <= emit;
            done         <= emit && in_last;
            if (state == IDLE && cfg_valid) begin
                addr_reg <= cfg_addr & ALIGN_MASK;
                cnt      <= '0;
                pack_buf <= '0;
            end else if (emit) begin
                write_data <= merged;
                write_addr <= addr_reg;
                addr_reg   <= addr_reg + ADDR_STEP;
                cnt        <= '0;
                pack_buf   <= '0;
            end else if (accept) begin
                pack_buf <= merged;
                cnt      <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_history_write_packer.sv
// Scoreboard bench for history_write_packer: expected writes are queued as beats are
// driven and popped by a monitor whenever write_enable is seen.
module tb_history_write_packer;

    localparam int AW = 32;
    localparam int PW = 16;
    localparam int IB = 4;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [PW*8-1:0] data;
        logic            done;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid;
    logic [AW-1:0]   cfg_addr;
    logic            in_valid;
    logic            in_ready;
    logic [IB*8-1:0] in_data;
    logic            in_last;
    logic [AW-1:0]   write_addr;
    logic [PW*8-1:0] write_data;
    logic            write_enable;
    logic            busy;
    logic            done;

    exp_t sb[$];
    int   we_cycles[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_writes = 0;
    int   cyc = 0;

    history_write_packer #(.ADDR_WIDTH(AW), .MATCH_PE_WIDTH(PW), .IN_BYTES(IB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && write_enable) begin
            n_writes++;
            we_cycles.push_back(cyc);
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%h data=%h", write_addr, write_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (write_addr !== e.addr || write_data !== e.data || done !== e.done) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h done=%b exp addr=%h data=%h done=%b",
                             write_addr, write_data, done, e.addr, e.data, e.done);
                end
            end
        end
        if (rst_n && done && !write_enable) begin
            n_vec++;
            n_err++;
            $display("FAIL done_without_write done=%b write_enable=%b", done, write_enable);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout sim_time=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic [AW-1:0] a, input logic [PW*8-1:0] d, input logic dn);
        exp_t e;
        e.addr = a; e.data = d; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic do_cfg(input logic [AW-1:0] a);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Drives one beat starting just after a rising edge; returns in_ready seen mid-cycle.
    task automatic beat(input logic [IB*8-1:0] d, input logic l, output logic rdy);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(output int left);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        left = sb.size();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clk);
        n_vec++;
        if ({in_ready, write_enable, busy, done} !== 4'b0 || write_addr !== '0 || write_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs rdy=%b we=%b busy=%b done=%b addr=%h data=%h exp all 0",
                     in_ready, write_enable, busy, done, write_addr, write_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word;
        logic rdy;
        int   w0, left;
        do_cfg(32'h0000_0100);
        push_exp(32'h0000_0100, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
        w0 = n_writes;
        beat(32'h03020100, 1'b0, rdy);
        beat(32'h07060504, 1'b0, rdy);
        beat(32'h0B0A0908, 1'b0, rdy);
        n_vec++;
        if (n_writes !== w0) begin
            n_err++;
            $display("FAIL early_write writes=%0d exp %0d", n_writes - w0, 0);
        end
        beat(32'h0F0E0D0C, 1'b1, rdy);
        @(negedge clk);
        n_vec++;
        if (write_enable !== 1'b1) begin
            n_err++;
            $display("FAIL write_latency we=%b exp 1", write_enable);
        end
        drain(left);
        n_vec++;
        if (left != 0 || n_writes - w0 != 1) begin
            n_err++;
            $display("FAIL single_word_count pending=%0d writes=%0d exp 0/1", left, n_writes - w0);
        end
    endtask

    task automatic test_back_to_back;
        logic                  rdy;
        logic [IB*8-1:0]       d;
        logic [PW*8-1:0]       w;
        int                    left, bad_ready;
        do_cfg(32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < PW; i++) w[8*i +: 8] = 8'(16*k + i + 8'h20);
            push_exp(32'h0000_0100 + 32'(16*k), w, k == 2);
        end
        we_cycles.delete();
        bad_ready = 0;
        for (int j = 0; j < 12; j++) begin
            for (int b = 0; b < IB; b++) d[8*b +: 8] = 8'(4*j + b + 8'h20);
            beat(d, j == 11, rdy);
            if (rdy !== 1'b1) bad_ready++;
        end
        drain(left);
        n_vec++;
        if (bad_ready != 0) begin
            n_err++;
            $display("FAIL b2b_in_ready dropped=%0d exp 0", bad_ready);
        end
        n_vec++;
        if (left != 0 || we_cycles.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count pending=%0d writes=%0d exp 0/3", left, we_cycles.size());
        end else begin
            n_vec++;
            if (we_cycles[1] - we_cycles[0] != 4 || we_cycles[2] - we_cycles[1] != 4) begin
                n_err++;
                $display("FAIL b2b_spacing gaps=%0d,%0d exp 4,4",
                         we_cycles[1] - we_cycles[0], we_cycles[2] - we_cycles[1]);
            end
        end
    endtask

    task automatic test_last_partial;
        logic rdy;
        int   left;
        do_cfg(32'h0000_0200);
        push_exp(32'h0000_0200, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 1'b1);
        beat(32'hAAAAAAAA, 1'b0, rdy);
        beat(32'hBBBBBBBB, 1'b1, rdy);
        @(negedge clk);
        n_vec++;
        if (write_enable !== 1'b1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL last_strobe we=%b done=%b exp 1/1", write_enable, done);
        end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL last_idle rdy=%b busy=%b done=%b exp 0/0/0", in_ready, busy, done);
        end
        drain(left);
        n_vec++;
        if (left != 0) begin
            n_err++;
            $display("FAIL last_pending pending=%0d exp 0", left);
        end
    endtask

    task automatic test_wrap;
        logic rdy;
        int   left;
        do_cfg(32'hFFFF_FFF0);
        push_exp(32'hFFFF_FFF0, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}, 1'b0);
        push_exp(32'h0000_0000, {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004}, 1'b1);
        for (int j = 0; j < 8; j++) beat(32'hC0DE0000 + 32'(j), j == 7, rdy);
        drain(left);
        n_vec++;
        if (left != 0) begin
            n_err++;
            $display("FAIL wrap_pending pending=%0d exp 0", left);
        end
    endtask

    task automatic test_align;
        logic rdy;
        int   left;
        // cfg and a beat together in IDLE: only cfg is taken.
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 32'h0000_0105;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_beat_collision rdy=%b exp 0", in_ready);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL align_busy busy=%b exp 1", busy);
        end
        push_exp(32'h0000_0100, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b1);
        beat(32'h11111111, 1'b0, rdy);
        beat(32'h22222222, 1'b0, rdy);
        beat(32'h33333333, 1'b0, rdy);
        beat(32'h44444444, 1'b1, rdy);
        drain(left);
        n_vec++;
        if (left != 0) begin
            n_err++;
            $display("FAIL align_pending pending=%0d exp 0", left);
        end
    endtask

    task automatic test_reset_mid_word;
        logic rdy;
        int   w0, left;
        do_cfg(32'h0000_0400);
        w0 = n_writes;
        beat(32'h99999999, 1'b0, rdy);
        beat(32'h88888888, 1'b0, rdy);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, busy, write_enable, done} !== 4'b0 || write_addr !== '0 || write_data !== '0) begin
            n_err++;
            $display("FAIL async_reset rdy=%b busy=%b we=%b done=%b addr=%h data=%h exp all 0",
                     in_ready, busy, write_enable, done, write_addr, write_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_cfg(32'h0000_0300);
        push_exp(32'h0000_0300, {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 1'b1);
        beat(32'h0000000A, 1'b0, rdy);
        beat(32'h0000000B, 1'b0, rdy);
        beat(32'h0000000C, 1'b0, rdy);
        beat(32'h0000000D, 1'b1, rdy);
        drain(left);
        n_vec++;
        if (left != 0 || n_writes - w0 != 1) begin
            n_err++;
            $display("FAIL reset_mid_word pending=%0d writes=%0d exp 0/1", left, n_writes - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_last_partial();
        test_wrap();
        test_align();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
